// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiplier: one operand pair in, 2*WIDTH product out as two WIDTH-bit beats.
// Optional SIGNED_MULT_EN build treats operands as two's complement (sign-magnitude internally).
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, OUT_LO, OUT_HI} state_t;

    state_t                 state;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [CW-1:0]          count;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [2*WIDTH-1:0]     acc_sum;
    logic [2*WIDTH-1:0]     prod_final;

    always_comb acc_sum = acc + (b_sh[0] ? a_sh : '0);

`ifdef SIGNED_MULT_EN
    logic neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic s);
        return s ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    always_comb begin
        mag_a      = magnitude(op_a);
        mag_b      = magnitude(op_b);
        prod_final = apply_sign(acc_sum, neg);
    end

    always_ff @(posedge clk) begin
        if (rst)
            neg <= 1'b0;
        else if (state == IDLE && in_valid)
            neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end
`else
    always_comb begin
        mag_a      = op_a;
        mag_b      = op_b;
        prod_final = acc_sum;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{WIDTH{1'b0}}, mag_a};
                        b_sh     <= mag_b;
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + CW'(1);
                    // Last partial product: the signed build negates here so beats need no extra cycle.
                    if (count == CW'(WIDTH - 1)) begin
                        acc       <= prod_final;
                        out_data  <= prod_final[WIDTH-1:0];
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT_LO;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                OUT_LO: begin
                    if (out_ready) begin
                        out_data <= acc[2*WIDTH-1:WIDTH];
                        out_last <= 1'b1;
                        state    <= OUT_HI;
                    end
                end
                OUT_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a beat scoreboard; honours SIGNED_MULT_EN like the design.
module tb_mult_seq_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
`ifdef SIGNED_MULT_EN
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
`else
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
`endif
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = model(a, b);
        exp_q.push_back({1'b0, p[W-1:0]});
        exp_q.push_back({1'b1, p[2*W-1:W]});
    endtask

    // Returns on the first negedge after the accepting clock edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 64'(in_ready), 64'(1));
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        push_exp(a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_busy", 64'(busy), 64'(1));
        check("accept_in_ready", 64'(in_ready), 64'(0));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 64'(out_valid), 64'(1));
    endtask

    task automatic take_beat(input string tag);
        int n;
        logic [W:0] e;
        wait_valid(n);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 64'(out_data), 64'(e[W-1:0]));
            check({tag, "_last"}, 64'(out_last), 64'(e[W]));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5 with first-beat latency
        send(32'd3, 32'd5);
        wait_valid(n);
        check("lat_3x5", 64'(n + 1), 64'(W + 1));
        check("lat_3x5_lo_raw", 64'(out_data), 64'h0000000F);
        take_beat("t1_lo");
        take_beat("t1_hi");

        // all-ones operands
        send(32'hFFFFFFFF, 32'hFFFFFFFF);
        take_beat("t2_lo");
        take_beat("t2_hi");

        // zero operands still take the full BUSY span
        send(32'd0, 32'd0);
        wait_valid(n);
        check("lat_zero", 64'(n + 1), 64'(W + 1));
        take_beat("t0_lo");
        take_beat("t0_hi");

        // backpressure in OUT_LO with stray in_valid pulses
        out_ready = 1'b0;
        send(32'h12345678, 32'h9ABCDEF0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            op_a = 32'hDEADBEEF;
            op_b = 32'hCAFEF00D;
            @(posedge clk);
            @(negedge clk);
            check("bp_data", 64'(out_data), 64'(exp_q[0][W-1:0]));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_last", 64'(out_last), 64'(0));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        take_beat("t3_lo");
        take_beat("t3_hi");

        // reset in the middle of BUSY
        send(32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        exp_q.delete();
        send(32'd7, 32'd6);
        take_beat("t4_lo");
        take_beat("t4_hi");

        // -1 x 1: result depends on the signed build option
        send(32'hFFFFFFFF, 32'h00000001);
        take_beat("t5_lo");
        take_beat("t5_hi");

        // most negative squared, exact in the signed build
        send(32'h80000000, 32'h80000000);
        take_beat("t7_lo");
        take_beat("t7_hi");

        // back-to-back with in_valid held high; operand change during BUSY must be ignored
        op_a = 32'd2;
        op_b = 32'd2;
        in_valid = 1'b1;
        push_exp(32'd2, 32'd2);
        @(posedge clk);
        @(negedge clk);
        op_a = 32'd4;
        op_b = 32'd4;
        push_exp(32'd4, 32'd4);
        take_beat("t6a_lo");
        take_beat("t6a_hi");
        check("b2b_idle_in_ready", 64'(in_ready), 64'(1));
        check("b2b_idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accept_busy", 64'(busy), 64'(1));
        check("b2b_accept_in_ready", 64'(in_ready), 64'(0));
        wait_valid(n);
        check("lat_b2b", 64'(n + 1), 64'(W + 1));
        take_beat("t6b_lo");
        take_beat("t6b_hi");

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
